dmem_wait: RTL
==============

DMEM_WAIT -- requirements
Module: dmem_wait

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, meaning the number of 32-bit words; it must be a power of two and at least 4.
REQ-002 SHALL have parameter LATENCY, default 2, meaning wait cycles per access; legal range is 1..15.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port req, input, 1 bit: access request; sampled only when it can be accepted.
REQ-006 SHALL have port we, input, 1 bit: 1 = store, 0 = load.
REQ-007 SHALL have port mode, input, 3 bits: RISC-V funct3. 000 = B, 001 = H, 010 = W, 100 = BU, 101 = HU.
REQ-008 SHALL have port a, input, 32 bits: byte address.
REQ-009 SHALL have port wd, input, 32 bits: store data, taken from the low lanes.
REQ-010 SHALL have port rd, output, 32 bits: load result, extended per mode.
REQ-011 SHALL have port busy, output, 1 bit: pipeline stall request.
REQ-012 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-013 SHALL have port err, output, 1 bit: one-cycle error pulse, coincident with done.

Function
REQ-014 SHALL implement a three-state FSM: IDLE, WAIT, DONE.
REQ-015 SHALL accept req in IDLE or DONE; on acceptance it latches a, wd, we and mode.
REQ-016 SHALL ignore req while in WAIT; a host must hold req until done.
REQ-017 SHALL handle a legal request by entering WAIT with cnt = LATENCY-1.
REQ-018 SHALL, in WAIT, decrement cnt each edge while cnt > 0.
REQ-019 SHALL, at the WAIT edge where cnt == 0, perform the access and enter DONE.
  - Result: done is high during the cycle after edge E0+LATENCY, where E0 is the accept edge.
REQ-020 SHALL, in DONE, assert done for exactly one cycle.
  - Next state is IDLE if req is low.
  - Next state is WAIT for a new request if req is high (back-to-back, no idle cycle).
REQ-021 SHALL drive busy = 1 in WAIT, and in IDLE/DONE when req is high; otherwise busy = 0.
REQ-022 SHALL detect misalignment and reserved modes.
  - Misaligned: H/HU with a[0] = 1; W with a[1:0] != 0.
  - Reserved: mode 011, 110, 111.
  - Either case on acceptance: go directly to DONE with done = 1 and err = 1.
  - No memory write; rd unchanged.
REQ-023 SHALL treat store modes 100 and 101 as reserved.
REQ-024 SHALL form the word index as a[log2(DEPTH_WORDS)+1:2]; upper address bits are ignored, so addresses wrap modulo 4*DEPTH_WORDS.
REQ-025 SHALL perform stores with byte enables.
  - SB writes lane a[1:0] with wd[7:0].
  - SH writes lanes a[1]*2 and a[1]*2+1 with wd[15:0].
  - SW writes all four lanes.
  - All other bytes of the word are preserved.
REQ-026 SHALL form load results from the selected lane(s).
  - B/H: sign-extended.
  - BU/HU: zero-extended.
  - W: the full word.
REQ-027 SHALL update rd only on a successful load completion; rd holds its value through stores, errors and idle cycles.
REQ-028 SHALL keep err low whenever done is low.

Reset
REQ-029 SHALL, on assertion of reset (asynchronous, any state):
  - set state = IDLE and cnt = 0;
  - set done = 0, err = 0, rd = 0;
  - drive busy to reflect only req;
  - clear all memory words to 0.
REQ-030 SHALL abort any in-flight access on reset; a pending store never writes.
REQ-031 SHALL accept a request at the first rising edge after reset deasserts.

Structure
REQ-032 SHALL place in a shared package:
  - the mode encodings (B, H, W, BU, HU);
  - the FSM state encoding;
  - a misalign/reserved check function.
REQ-033 SHALL place store lane steering, byte-enable generation and load extension in one combinational sub-module, dmem_lane_fmt.
REQ-034 SHALL keep the memory array, FSM and counter in dmem_wait.

Verification
REQ-035 SHALL cover store then load, LATENCY=2:
  - Stimulus: SW a=0x10 wd=0xDEADBEEF, then LW a=0x10.
  - Response: done 2 cycles after each accept; rd=0xDEADBEEF; err=0.
REQ-036 SHALL cover lanes:
  - Stimulus: SB a=0x13 wd=0x80, then LB a=0x13 and LBU a=0x13.
  - Response: rd=0xFFFFFF80 and rd=0x00000080 respectively; word 0x10 bytes 0..2 unchanged.
REQ-037 SHALL cover misalignment:
  - Stimulus: LW a=0x22, or SH a=0x21.
  - Response: done=err=1 in the cycle after accept; memory and rd unchanged.
REQ-038 SHALL cover back-to-back requests:
  - Stimulus: req held high across 3 loads.
  - Response: done pulses spaced LATENCY+1 cycles apart; busy low only in DONE cycles with req low at the end.
REQ-039 SHALL cover reset mid-WAIT:
  - Stimulus: SW a=0x4 wd=0x1234, reset asserted at cnt=1, then LW a=0x4.
  - Response: no done from the aborted access; rd=0x00000000.
REQ-040 SHALL cover wrap-around, DEPTH_WORDS=256:
  - Stimulus: SW a=0x400 wd=0x55, then LW a=0x0.
  - Response: rd=0x00000055.

Source files
------------

// File: rtl/dmem_wait_pkg.sv
// Shared encodings and access-legality check for the wait-state data memory.
package dmem_wait_pkg;

  // RISC-V load/store funct3 encodings
  localparam logic [2:0] MODE_B  = 3'b000;
  localparam logic [2:0] MODE_H  = 3'b001;
  localparam logic [2:0] MODE_W  = 3'b010;
  localparam logic [2:0] MODE_BU = 3'b100;
  localparam logic [2:0] MODE_HU = 3'b101;

  // Wait counter is wide enough for LATENCY up to 15
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // High when the access is misaligned or uses a reserved mode (unsigned stores are reserved)
  function automatic logic access_err(input logic we, input logic [2:0] mode,
                                      input logic [1:0] alo);
    logic e;
    e = 1'b0;
    case (mode)
      MODE_B:  e = 1'b0;
      MODE_H:  e = alo[0];
      MODE_W:  e = (alo != 2'b00);
      MODE_BU: e = we;
      MODE_HU: e = we | alo[0];
      default: e = 1'b1;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/dmem_lane_fmt.sv
// Store lane steering, byte-enable generation and load extension.
module dmem_lane_fmt
  import dmem_wait_pkg::*;
(
  input  logic [2:0]  mode,
  input  logic [1:0]  alo,
  input  logic [31:0] wd,
  input  logic [31:0] rword,
  output logic [31:0] wdata_c,
  output logic [3:0]  be_c,
  output logic [31:0] ld_c
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed byte and halfword out of the stored word
  always_comb begin
    byte_sel = rword[7:0];
    case (alo)
      2'd0: byte_sel = rword[7:0];
      2'd1: byte_sel = rword[15:8];
      2'd2: byte_sel = rword[23:16];
      2'd3: byte_sel = rword[31:24];
      default: byte_sel = rword[7:0];
    endcase
    half_sel = alo[1] ? rword[31:16] : rword[15:0];
  end

  // Replicate store data across lanes and enable only the addressed ones
  always_comb begin
    wdata_c = wd;
    be_c    = 4'b0000;
    case (mode)
      MODE_B: begin
        wdata_c = {4{wd[7:0]}};
        be_c    = 4'b0001 << alo;
      end
      MODE_H: begin
        wdata_c = {2{wd[15:0]}};
        be_c    = alo[1] ? 4'b1100 : 4'b0011;
      end
      MODE_W: begin
        wdata_c = wd;
        be_c    = 4'b1111;
      end
      default: begin
        wdata_c = wd;
        be_c    = 4'b0000;
      end
    endcase
  end

  // Sign- or zero-extend the selected lane(s) into the load result
  always_comb begin
    ld_c = rword;
    case (mode)
      MODE_B:  ld_c = {{24{byte_sel[7]}}, byte_sel};
      MODE_H:  ld_c = {{16{half_sel[15]}}, half_sel};
      MODE_W:  ld_c = rword;
      MODE_BU: ld_c = {24'd0, byte_sel};
      MODE_HU: ld_c = {16'd0, half_sel};
      default: ld_c = rword;
    endcase
  end

endmodule

// File: rtl/dmem_wait.sv
// Word-organised data memory with a fixed number of wait states per access.
module dmem_wait
  import dmem_wait_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [2:0]  mode,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int unsigned IDX_W  = $clog2(DEPTH_WORDS);
  localparam int unsigned ADDR_W = IDX_W + 2;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [31:0]        mem [DEPTH_WORDS];

  logic [ADDR_W-1:0]  lat_a;
  logic [31:0]        lat_wd;
  logic               lat_we;
  logic [2:0]         lat_mode;

  logic [IDX_W-1:0]   idx;
  logic [31:0]        rword;
  logic [31:0]        wdata;
  logic [3:0]         be;
  logic [31:0]        ld;
  logic               unused_addr_bits;

  // Upper address bits fold away: the memory wraps modulo its byte size
  assign unused_addr_bits = ^a[31:ADDR_W];

  assign idx   = lat_a[ADDR_W-1:2];
  assign rword = mem[idx];

  // Stall the host while an access is in flight or a new one is being offered
  assign busy = (state == ST_WAIT) | req;

  dmem_lane_fmt u_lane_fmt (
    .mode    (lat_mode),
    .alo     (lat_a[1:0]),
    .wd      (lat_wd),
    .rword   (rword),
    .wdata_c (wdata),
    .be_c    (be),
    .ld_c    (ld)
  );

  // Request FSM, wait counter, memory array and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
      rd       <= '0;
      lat_a    <= '0;
      lat_wd   <= '0;
      lat_we   <= 1'b0;
      lat_mode <= '0;
      for (int i = 0; i < int'(DEPTH_WORDS); i++) begin
        mem[IDX_W'(i)] <= '0;
      end
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (req) begin
            lat_a    <= a[ADDR_W-1:0];
            lat_wd   <= wd;
            lat_we   <= we;
            lat_mode <= mode;
            if (access_err(we, mode, a[1:0])) begin
              // Illegal access completes immediately with no side effects
              state <= ST_DONE;
              done  <= 1'b1;
              err   <= 1'b1;
            end else begin
              state <= ST_WAIT;
              cnt   <= CNT_W'(LATENCY - 1);
            end
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            state <= ST_DONE;
            done  <= 1'b1;
            if (lat_we) begin
              for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
              end
            end else begin
              rd <= ld;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
